// File: rtl/vanilla_issue_scoreboard_pkg.sv
// Shared types for the vanilla ID-stage issue scoreboard.
// Clear-port numbering, decoded instruction and control bundles.
package bsg_vanilla_pkg;

    localparam int vanilla_sb_num_clear_ports_gp = 2;

    typedef enum logic [0:0] {
        e_sb_clear_remote,
        e_sb_clear_idiv
    } vanilla_sb_clear_port_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] op;
    } instruction_s;

    typedef struct packed {
        logic read_rs1;
        logic read_rs2;
        logic write_rd;
        logic is_load_op;
        logic is_amo_op;
        logic is_lr_op;
        logic is_idiv_op;
    } decode_s;

    function automatic logic [1:0] vanilla_sb_popcount(
        input logic [vanilla_sb_num_clear_ports_gp-1:0] v
    );
        logic [1:0] n;
        n = '0;
        for (int i = 0; i < vanilla_sb_num_clear_ports_gp; i++) begin
            n = n + {1'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/vanilla_issue_scoreboard_if.sv
// ID-stage <-> scoreboard bundle: decoded instruction in, stall/status out.
// master = ID stage / writeback side, slave = scoreboard.
interface vanilla_issue_scoreboard_if #(
    parameter int els_p     = 32,
    parameter int max_out_p = 16
);
    import bsg_vanilla_pkg::*;

    localparam int id_w  = $clog2(els_p);
    localparam int cnt_w = $clog2(max_out_p + 1);
    localparam int np    = vanilla_sb_num_clear_ports_gp;

    logic                    v_i;
    instruction_s            instruction_i;
    decode_s                 decode_i;
    logic                    score_i;
    logic [np-1:0]           clear_v_i;
    logic [np-1:0][id_w-1:0] clear_id_i;
    logic                    dependency_o;
    logic                    long_op_o;
    logic [cnt_w-1:0]        out_count_o;
    logic                    empty_o;

    modport master (
        output v_i, instruction_i, decode_i, score_i,
        output clear_v_i, clear_id_i,
        input  dependency_o, long_op_o, out_count_o, empty_o
    );

    modport slave (
        input  v_i, instruction_i, decode_i, score_i,
        input  clear_v_i, clear_id_i,
        output dependency_o, long_op_o, out_count_o, empty_o
    );

endinterface

// File: rtl/vanilla_sb_out_counter.sv
// Up/down count of outstanding long-latency ops: one increment and
// one decrement per clear port each cycle, clamped and checked.
module vanilla_sb_out_counter
    import bsg_vanilla_pkg::*;
#(
    parameter int max_out_p = 16,
    localparam int cnt_w    = $clog2(max_out_p + 1),
    localparam int np       = vanilla_sb_num_clear_ports_gp
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             up_i,
    input  logic [np-1:0]    down_i,
    output logic [cnt_w-1:0] count_o
);

    logic [cnt_w-1:0] count_q, count_d;
    logic [cnt_w+1:0] up_sum, down_sum, diff;
    logic             under, over;

    always_comb begin
        up_sum   = (cnt_w+2)'(count_q) + (cnt_w+2)'(up_i);
        down_sum = (cnt_w+2)'(vanilla_sb_popcount(down_i));
        diff     = up_sum - down_sum;
        under    = down_sum > up_sum;
        over     = !under && (diff > (cnt_w+2)'(max_out_p));
        count_d  = cnt_w'(diff);
        if (under) count_d = '0;
        if (over)  count_d = cnt_w'(max_out_p);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (under) $error("vanilla_sb_out_counter: underflow");
            if (over)  $error("vanilla_sb_out_counter: overflow");
        end
    end
`endif

endmodule

// File: rtl/vanilla_issue_scoreboard.sv
// ID-stage RAW/WAW scoreboard for long-latency integer ops.
// VANILLA_SB_CLEAR_BYPASS_EN: same-cycle clears hide pending bits from the stall.
module vanilla_issue_scoreboard
    import bsg_vanilla_pkg::*;
#(
    parameter int els_p     = 32,
    parameter int max_out_p = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    vanilla_issue_scoreboard_if.slave sb_if
);

    localparam int id_w  = $clog2(els_p);
    localparam int cnt_w = $clog2(max_out_p + 1);
    localparam int np    = vanilla_sb_num_clear_ports_gp;

    logic [els_p-1:0] sb_q, sb_d, sb_eff, set_mask, clr_mask;
    logic [id_w-1:0]  rs1_id, rs2_id, rd_id;
    logic [cnt_w-1:0] out_count;
    logic             raw, waw, full, long_op, dep;
    logic             unused_instr;

    assign rs1_id = id_w'(sb_if.instruction_i.rs1);
    assign rs2_id = id_w'(sb_if.instruction_i.rs2);
    assign rd_id  = id_w'(sb_if.instruction_i.rd);

    assign unused_instr = ^{sb_if.instruction_i.funct7,
                            sb_if.instruction_i.funct3,
                            sb_if.instruction_i.op};

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (sb_if.score_i && sb_if.decode_i.write_rd && rd_id != '0)
            set_mask[rd_id] = 1'b1;
        for (int p = 0; p < np; p++) begin
            if (sb_if.clear_v_i[p]) clr_mask[sb_if.clear_id_i[p]] = 1'b1;
        end
    end

    // set beats clear; x0 can never be pending
    assign sb_d = ((sb_q & ~clr_mask) | set_mask) & {{(els_p-1){1'b1}}, 1'b0};

    always_ff @(posedge clk_i) begin
        if (reset_i) sb_q <= '0;
        else         sb_q <= sb_d;
    end

`ifdef VANILLA_SB_CLEAR_BYPASS_EN
    assign sb_eff = sb_q & ~clr_mask;
`else
    assign sb_eff = sb_q;
`endif

    vanilla_sb_out_counter #(
        .max_out_p (max_out_p)
    ) u_out_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .up_i    (sb_if.score_i),
        .down_i  (sb_if.clear_v_i),
        .count_o (out_count)
    );

    assign long_op = sb_if.decode_i.is_load_op | sb_if.decode_i.is_amo_op
                   | sb_if.decode_i.is_lr_op   | sb_if.decode_i.is_idiv_op;

    assign raw  = (sb_if.decode_i.read_rs1 & sb_eff[rs1_id])
                | (sb_if.decode_i.read_rs2 & sb_eff[rs2_id]);
    assign waw  = sb_if.decode_i.write_rd & sb_eff[rd_id];
    assign full = long_op & (out_count == cnt_w'(max_out_p));
    assign dep  = sb_if.v_i & (raw | waw | full);

    assign sb_if.dependency_o = dep;
    assign sb_if.long_op_o    = long_op;
    assign sb_if.out_count_o  = out_count;
    assign sb_if.empty_o      = ~|sb_q & (out_count == '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (sb_if.score_i && dep)
                $error("vanilla_issue_scoreboard: score while stalled");
            for (int p = 0; p < np; p++) begin
                if (sb_if.clear_v_i[p] && sb_if.clear_id_i[p] != '0
                    && !sb_q[sb_if.clear_id_i[p]])
                    $error("vanilla_issue_scoreboard: clear of idle reg %0d",
                           sb_if.clear_id_i[p]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vanilla_issue_scoreboard.sv
// Directed plus randomized bench for vanilla_issue_scoreboard.
// Random phase checks against a pending-set / op-list reference model.
module tb_vanilla_issue_scoreboard;
    import bsg_vanilla_pkg::*;

    localparam int ELS  = 32;
    localparam int MAXO = 16;
`ifdef VANILLA_SB_CLEAR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    vanilla_issue_scoreboard_if #(.els_p(ELS), .max_out_p(MAXO)) sb_if ();

    vanilla_issue_scoreboard #(.els_p(ELS), .max_out_p(MAXO)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sb_if   (sb_if)
    );

    int checks   = 0;
    int failures = 0;

    bit pend [ELS];
    int cnt;
    int q_rd[$];
    int q_port[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // cls: 0 alu, 1 load, 2 amo, 3 lr, 4 idiv, 5 store
    task automatic drive_id(input logic v, input int cls, input int rs1,
                            input int rs2, input int rd, input logic r1,
                            input logic r2, input logic w);
        instruction_s ins;
        decode_s      d;
        ins = '0;
        ins.rs1 = 5'(rs1);
        ins.rs2 = 5'(rs2);
        ins.rd  = 5'(rd);
        d = '0;
        d.read_rs1   = r1;
        d.read_rs2   = r2;
        d.write_rd   = w;
        d.is_load_op = (cls == 1);
        d.is_amo_op  = (cls == 2);
        d.is_lr_op   = (cls == 3);
        d.is_idiv_op = (cls == 4);
        sb_if.v_i           = v;
        sb_if.instruction_i = ins;
        sb_if.decode_i      = d;
    endtask

    task automatic clr(input logic v0, input int id0, input logic v1,
                       input int id1);
        sb_if.clear_v_i     = {v1, v0};
        sb_if.clear_id_i[0] = 5'(id0);
        sb_if.clear_id_i[1] = 5'(id1);
    endtask

    task automatic quiet;
        sb_if.score_i = 1'b0;
        clr(1'b0, 0, 1'b0, 0);
        drive_id(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick;
        @(negedge clk_i);
        quiet();
    endtask

    initial begin
        reset_i = 1'b1;
        quiet();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check("reset_count", 32'(sb_if.out_count_o), 0);
        check("reset_empty", 32'(sb_if.empty_o), 1);
        check("reset_dep", 32'(sb_if.dependency_o), 0);
        tick();

        // load to x5, then dependent ADD
        drive_id(1, 1, 0, 0, 5, 0, 0, 1);
        sb_if.score_i = 1;
        #1 check("ld5_long", 32'(sb_if.long_op_o), 1);
        check("ld5_dep", 32'(sb_if.dependency_o), 0);
        tick();
        drive_id(1, 0, 5, 6, 10, 1, 1, 1);
        #1 check("raw5_dep", 32'(sb_if.dependency_o), 1);
        check("raw5_count", 32'(sb_if.out_count_o), 1);
        check("raw5_empty", 32'(sb_if.empty_o), 0);
        tick();
        drive_id(1, 0, 5, 6, 10, 1, 1, 1);
        clr(1, 5, 0, 0);
        #1 check("raw5_clr_dep", 32'(sb_if.dependency_o), BYP ? 0 : 1);
        tick();
        drive_id(1, 0, 5, 6, 10, 1, 1, 1);
        #1 check("raw5_after_dep", 32'(sb_if.dependency_o), 0);
        check("raw5_after_empty", 32'(sb_if.empty_o), 1);
        tick();

        // WAW on x7, store reading only rs1
        drive_id(1, 1, 2, 0, 7, 1, 0, 1);
        sb_if.score_i = 1;
        tick();
        drive_id(1, 1, 2, 0, 7, 1, 0, 1);
        #1 check("waw7_dep", 32'(sb_if.dependency_o), 1);
        drive_id(1, 5, 3, 7, 7, 1, 0, 0);
        #1 check("sw_dep", 32'(sb_if.dependency_o), 0);
        check("sw_long", 32'(sb_if.long_op_o), 0);
        clr(1, 7, 0, 0);
        tick();

        // fill the counter
        for (int i = 0; i < MAXO; i++) begin
            drive_id(1, 1, 20, 0, i + 1, 1, 0, 1);
            sb_if.score_i = 1;
            #1 check("fill_dep", 32'(sb_if.dependency_o), 0);
            tick();
        end
        check("full_count", 32'(sb_if.out_count_o), MAXO);
        drive_id(1, 4, 20, 21, 25, 1, 1, 1);
        #1 check("full_div_dep", 32'(sb_if.dependency_o), 1);
        drive_id(1, 0, 20, 21, 22, 1, 1, 1);
        #1 check("full_add_dep", 32'(sb_if.dependency_o), 0);
        drive_id(1, 4, 20, 21, 25, 1, 1, 1);
        clr(1, 1, 0, 0);
        #1 check("full_clr_dep", 32'(sb_if.dependency_o), 1);
        tick();
        for (int r = 2; r <= MAXO; r += 2) begin
            clr(1, r, (r + 1 <= MAXO), r + 1);
            tick();
        end
        check("drain_count", 32'(sb_if.out_count_o), 0);
        check("drain_empty", 32'(sb_if.empty_o), 1);

        // double clear of x9 plus re-score of x9 in one cycle
        drive_id(1, 1, 0, 0, 9, 0, 0, 1);
        sb_if.score_i = 1;
        tick();
        drive_id(1, 2, 0, 0, 0, 0, 0, 1);
        sb_if.score_i = 1;
        tick();
        check("dbl_pre_count", 32'(sb_if.out_count_o), 2);
        drive_id(0, 1, 0, 0, 9, 0, 0, 1);
        sb_if.score_i = 1;
        clr(1, 9, 1, 9);
        tick();
        check("dbl_count", 32'(sb_if.out_count_o), 1);
        drive_id(1, 0, 9, 0, 3, 1, 0, 1);
        #1 check("dbl_sb9_dep", 32'(sb_if.dependency_o), 1);
        check("dbl_empty", 32'(sb_if.empty_o), 0);
        clr(1, 9, 0, 0);
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("dbl_end_count", 32'(sb_if.out_count_o), 0);

        // AMO to x0
        drive_id(1, 2, 3, 4, 0, 1, 1, 1);
        sb_if.score_i = 1;
        #1 check("amo0_dep", 32'(sb_if.dependency_o), 0);
        tick();
        check("amo0_count", 32'(sb_if.out_count_o), 1);
        check("amo0_empty", 32'(sb_if.empty_o), 0);
        drive_id(1, 0, 0, 0, 1, 1, 1, 1);
        #1 check("amo0_x0_dep", 32'(sb_if.dependency_o), 0);
        clr(1, 0, 0, 0);
        tick();
        check("amo0_clr_count", 32'(sb_if.out_count_o), 0);
        check("amo0_clr_empty", 32'(sb_if.empty_o), 1);

        // reset in the middle of a pending op
        drive_id(1, 1, 0, 0, 4, 0, 0, 1);
        sb_if.score_i = 1;
        tick();
        check("mid_empty", 32'(sb_if.empty_o), 0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        drive_id(1, 0, 4, 4, 4, 1, 1, 1);
        #1 check("mid_rst_dep", 32'(sb_if.dependency_o), 0);
        check("mid_rst_count", 32'(sb_if.out_count_o), 0);
        check("mid_rst_empty", 32'(sb_if.empty_o), 1);
        tick();

        // randomized phase against the reference model
        for (int r = 0; r < ELS; r++) pend[r] = 0;
        cnt = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            int   cls, rs1, rs2, rd, nclr;
            logic v, r1, r2, w, lng, exp_dep, sc, e_rs1, e_rs2, e_rd, anyp;
            logic [1:0] cv;
            int   cid [2];
            cls = $urandom_range(0, 5);
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            rd  = $urandom_range(0, 7);
            v   = ($urandom_range(0, 3) != 0);
            r1  = 1'($urandom_range(0, 1));
            r2  = (cls == 1 || cls == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            w   = (cls == 5) ? 1'b0 : 1'($urandom_range(0, 1));
            lng = (cls >= 1 && cls <= 4);

            cv = '0;
            for (int p = 0; p < 2; p++) begin
                cid[p] = 0;
                if ($urandom_range(0, 2) == 0) begin
                    for (int i = 0; i < q_rd.size(); i++) begin
                        if (!cv[p] && q_port[i] == p) begin
                            cv[p]  = 1'b1;
                            cid[p] = q_rd[i];
                            q_rd.delete(i);
                            q_port.delete(i);
                        end
                    end
                end
            end
            nclr = int'(cv[0]) + int'(cv[1]);

            e_rs1 = pend[rs1] && !(BYP && ((cv[0] && cid[0] == rs1) || (cv[1] && cid[1] == rs1)));
            e_rs2 = pend[rs2] && !(BYP && ((cv[0] && cid[0] == rs2) || (cv[1] && cid[1] == rs2)));
            e_rd  = pend[rd]  && !(BYP && ((cv[0] && cid[0] == rd)  || (cv[1] && cid[1] == rd)));
            exp_dep = v && ((r1 && e_rs1) || (r2 && e_rs2) || (w && e_rd)
                            || (lng && cnt == MAXO));
            sc = v && lng && !exp_dep && ($urandom_range(0, 1) == 1);

            anyp = 1'b0;
            for (int r = 0; r < ELS; r++) anyp = anyp | pend[r];

            drive_id(v, cls, rs1, rs2, rd, r1, r2, w);
            clr(cv[0], cid[0], cv[1], cid[1]);
            sb_if.score_i = sc;
            #1;
            check("rnd_dep", 32'(sb_if.dependency_o), 32'(exp_dep));
            check("rnd_long", 32'(sb_if.long_op_o), 32'(lng));
            check("rnd_count", 32'(sb_if.out_count_o), cnt);
            check("rnd_empty", 32'(sb_if.empty_o), 32'(cnt == 0 && !anyp));

            for (int p = 0; p < 2; p++) if (cv[p]) pend[cid[p]] = 0;
            if (sc) begin
                if (w && rd != 0) pend[rd] = 1;
                q_rd.push_back(w ? rd : 0);
                q_port.push_back(cls == 4 ? 1 : 0);
            end
            cnt = cnt + int'(sc) - nclr;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
